// File: rtl/conv_pkg.sv
// Shared definitions for the convolution slice: memory geometry and the
// loader state type. Also used by img_controller and the testbenches.
package conv_pkg;

  localparam int IMG_AW       = 10;
  localparam int IMG_DEPTH    = 1024;
  localparam int W_AW         = 8;
  localparam int W_DEPTH      = 256;
  localparam int DW           = 8;
  localparam int START_CYCLES = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_LOAD_IMG,
    ST_START,
    ST_WAIT_DONE
  } loader_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bram_wr_port.sv
// Registered BRAM port-A write driver: a handshake in one cycle becomes a
// single-cycle enable/write strobe with address and data in the next cycle.
module bram_wr_port #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic          ena,
  output logic          wea,
  output logic [AW-1:0] addra,
  output logic [DW-1:0] dina
);

  // Strobe for one cycle per accepted byte; address/data hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ena   <= 1'b0;
      wea   <= 1'b0;
      addra <= '0;
      dina  <= '0;
    end else begin
      ena <= wr;
      wea <= wr;
      if (wr) begin
        addra <= addr;
        dina  <= data;
      end
    end
  end

endmodule

// File: rtl/conv_input_loader.sv
// Stream loader: fills the weight BRAM, then the image BRAM, from a
// valid/ready byte stream, then launches img_controller and waits for done.
module conv_input_loader #(
  parameter int IMG_AW       = conv_pkg::IMG_AW,
  parameter int IMG_DEPTH    = conv_pkg::IMG_DEPTH,
  parameter int W_AW         = conv_pkg::W_AW,
  parameter int W_DEPTH      = conv_pkg::W_DEPTH,
  parameter int DW           = conv_pkg::DW,
  parameter int START_CYCLES = conv_pkg::START_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  output logic              w_ena,
  output logic              w_wea,
  output logic [W_AW-1:0]   w_addra,
  output logic [DW-1:0]     w_dina,
  output logic              img_ena,
  output logic              img_wea,
  output logic [IMG_AW-1:0] img_addra,
  output logic [DW-1:0]     img_dina,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              frame_done
);

  import conv_pkg::*;

  localparam int CNT_W = max_int(IMG_AW, W_AW) + 1;
  localparam int SC_W  = $clog2(START_CYCLES + 1);

  loader_state_t    state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [SC_W-1:0]  sc_cnt, sc_cnt_next;
  logic             frame_done_next;
  logic             hs;
  logic             w_wr;
  logic             img_wr;

  assign s_ready = (state == ST_LOAD_W) || (state == ST_LOAD_IMG);
  assign hs      = s_valid & s_ready;
  assign w_wr    = hs && (state == ST_LOAD_W);
  assign img_wr  = hs && (state == ST_LOAD_IMG);
  assign busy    = (state != ST_IDLE);
  // The first START cycle drains the final image strobe, so start is held
  // off for it and the controller never sees an uncommitted byte.
  assign start   = (state == ST_START) && (sc_cnt != '0);

  // State, beat counter, start-pulse counter and the frame_done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sc_cnt     <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      sc_cnt     <= sc_cnt_next;
      frame_done <= frame_done_next;
    end
  end

  // Next-state logic: weights then image, start pulse, then wait for done.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    sc_cnt_next     = sc_cnt;
    frame_done_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_req) begin
          state_next = ST_LOAD_W;
          cnt_next   = '0;
        end
      end
      ST_LOAD_W: begin
        if (hs) begin
          if (cnt == CNT_W'(W_DEPTH - 1)) begin
            cnt_next   = '0;
            state_next = ST_LOAD_IMG;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      ST_LOAD_IMG: begin
        if (hs) begin
          if (cnt == CNT_W'(IMG_DEPTH - 1)) begin
            cnt_next    = '0;
            sc_cnt_next = '0;
            state_next  = ST_START;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      ST_START: begin
        if (sc_cnt == SC_W'(START_CYCLES)) begin
          sc_cnt_next = '0;
          state_next  = ST_WAIT_DONE;
        end else begin
          sc_cnt_next = sc_cnt + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (done) begin
          frame_done_next = 1'b1;
          state_next      = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  bram_wr_port #(
    .AW (W_AW),
    .DW (DW)
  ) u_w_port (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (w_wr),
    .addr  (cnt[W_AW-1:0]),
    .data  (s_data),
    .ena   (w_ena),
    .wea   (w_wea),
    .addra (w_addra),
    .dina  (w_dina)
  );

  bram_wr_port #(
    .AW (IMG_AW),
    .DW (DW)
  ) u_img_port (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (img_wr),
    .addr  (cnt[IMG_AW-1:0]),
    .data  (s_data),
    .ena   (img_ena),
    .wea   (img_wea),
    .addra (img_addra),
    .dina  (img_dina)
  );

endmodule

// File: tb/tb_conv_input_loader.sv
// Self-checking bench for conv_input_loader: a byte-count/timestamp model
// predicts ready, strobes, start, busy and frame_done every cycle.
module tb_conv_input_loader;

  import conv_pkg::*;

  localparam int TOTAL = W_DEPTH + IMG_DEPTH;
  localparam int SC    = START_CYCLES;

  logic              clk;
  logic              rst_n;
  logic              load_req;
  logic              s_valid;
  logic              s_ready;
  logic [DW-1:0]     s_data;
  logic              w_ena;
  logic              w_wea;
  logic [W_AW-1:0]   w_addra;
  logic [DW-1:0]     w_dina;
  logic              img_ena;
  logic              img_wea;
  logic [IMG_AW-1:0] img_addra;
  logic [DW-1:0]     img_dina;
  logic              start;
  logic              done;
  logic              busy;
  logic              frame_done;

  conv_input_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_req   (load_req),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .w_ena      (w_ena),
    .w_wea      (w_wea),
    .w_addra    (w_addra),
    .w_dina     (w_dina),
    .img_ena    (img_ena),
    .img_wea    (img_wea),
    .img_addra  (img_addra),
    .img_dina   (img_dina),
    .start      (start),
    .done       (done),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  // Reference model: a frame is "loading" until TOTAL bytes are taken, then
  // "finishing" until done is seen at least SC+2 cycles after the last byte.
  bit   m_loading   = 0;
  bit   m_finishing = 0;
  int   m_acc       = 0;
  int   m_last_hs   = 0;
  bit   m_stb_w     = 0;
  bit   m_stb_i     = 0;
  bit   m_fd        = 0;
  int   m_w_addr    = 0;
  int   m_w_data    = 0;
  int   m_i_addr    = 0;
  int   m_i_data    = 0;

  bit   start_seen  = 0;
  int   start_cyc   = 0;
  int   start_cnt   = 0;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive one clock of inputs, check every output, then advance the model.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic lr, input logic dn);
    bit exp_ready;
    bit exp_start;
    bit was_idle;
    @(posedge clk);
    #1;
    cyc++;
    s_valid  = v;
    s_data   = d;
    load_req = lr;
    done     = dn;
    @(negedge clk);
    exp_ready = m_loading;
    exp_start = m_finishing && (cyc >= m_last_hs + 2) && (cyc <= m_last_hs + 1 + SC);
    was_idle  = !m_loading && !m_finishing;
    checkOutput("s_ready",    s_ready,    exp_ready);
    checkOutput("busy",       busy,       !was_idle);
    checkOutput("start",      start,      exp_start);
    checkOutput("frame_done", frame_done, m_fd);
    checkOutput("w_ena",      w_ena,      m_stb_w);
    checkOutput("w_wea",      w_wea,      m_stb_w);
    checkOutput("w_addra",    w_addra,    m_w_addr);
    checkOutput("w_dina",     w_dina,     m_w_data);
    checkOutput("img_ena",    img_ena,    m_stb_i);
    checkOutput("img_wea",    img_wea,    m_stb_i);
    checkOutput("img_addra",  img_addra,  m_i_addr);
    checkOutput("img_dina",   img_dina,   m_i_data);
    if (start) begin
      start_cnt++;
      if (!start_seen) begin
        start_seen = 1;
        start_cyc  = cyc;
      end
    end
    m_stb_w = 0;
    m_stb_i = 0;
    m_fd    = 0;
    if (exp_ready && v) begin
      if (m_acc < W_DEPTH) begin
        m_stb_w  = 1;
        m_w_addr = m_acc;
        m_w_data = d;
      end else begin
        m_stb_i  = 1;
        m_i_addr = m_acc - W_DEPTH;
        m_i_data = d;
      end
      m_acc++;
      if (m_acc == TOTAL) begin
        m_loading   = 0;
        m_finishing = 1;
        m_last_hs   = cyc;
      end
    end else if (was_idle && lr) begin
      m_loading = 1;
      m_acc     = 0;
    end
    if (m_finishing && (cyc >= m_last_hs + 2 + SC) && dn) begin
      m_finishing = 0;
      m_fd        = 1;
    end
  endtask

  // Asynchronous reset in the middle of a cycle; all outputs must drop at once.
  task automatic applyReset();
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    load_req = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    done     = 1'b0;
    #1;
    checkOutput("rst_s_ready",    s_ready,    0);
    checkOutput("rst_w_ena",      w_ena,      0);
    checkOutput("rst_w_wea",      w_wea,      0);
    checkOutput("rst_w_addra",    w_addra,    0);
    checkOutput("rst_w_dina",     w_dina,     0);
    checkOutput("rst_img_ena",    img_ena,    0);
    checkOutput("rst_img_wea",    img_wea,    0);
    checkOutput("rst_img_addra",  img_addra,  0);
    checkOutput("rst_img_dina",   img_dina,   0);
    checkOutput("rst_start",      start,      0);
    checkOutput("rst_busy",       busy,       0);
    checkOutput("rst_frame_done", frame_done, 0);
    m_loading   = 0;
    m_finishing = 0;
    m_acc       = 0;
    m_stb_w     = 0;
    m_stb_i     = 0;
    m_fd        = 0;
    m_w_addr    = 0;
    m_w_data    = 0;
    m_i_addr    = 0;
    m_i_data    = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Run one frame. mode 0: continuous index data with spurious done/load_req;
  // mode 1: valid toggling 0/1; mode 2: random valid, data and spurious pulses.
  // abort_at > 0 stops after that many accepted bytes.
  task automatic runFrame(input int mode, input int abort_at, output int c0);
    bit         finished;
    bit         v;
    bit         lr;
    bit         dn;
    logic [7:0] d;
    int         rel;
    finished   = 0;
    start_seen = 0;
    start_cnt  = 0;
    applyStimulus(1'b0, 8'($urandom), 1'b1, 1'b0);
    c0 = cyc;
    for (int k = 0; k < 6000; k++) begin
      if (abort_at > 0 && m_acc == abort_at) begin
        finished = 1;
        break;
      end
      if (!m_loading && !m_finishing && !m_fd) begin
        finished = 1;
        break;
      end
      rel = cyc + 1 - c0;
      lr  = 1'b0;
      dn  = 1'b0;
      case (mode)
        0: begin
          v  = 1'b1;
          d  = 8'(m_acc);
          lr = (rel == 600);
          dn = (rel == 100);
        end
        1: begin
          v = (rel % 2 == 0);
          d = 8'($urandom);
        end
        default: begin
          v  = ($urandom % 4) != 0;
          d  = 8'($urandom);
          lr = m_loading && (($urandom % 16) == 0);
          dn = m_loading && (($urandom % 16) == 0);
        end
      endcase
      if (m_finishing && (cyc + 1 >= m_last_hs + SC + 6)) dn = 1'b1;
      applyStimulus(v, d, lr, dn);
    end
    if (!finished) checkOutput("frame_timeout", 1, 0);
  endtask

  initial begin
    int c0;
    rst_n    = 1'b0;
    load_req = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    done     = 1'b0;
    $display("[TB] starting conv_input_loader bench");
    applyReset();

    // Stream presented while idle must be ignored.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);

    runFrame(0, 0, c0);
    checkOutput("start_cycle_cont", start_cyc - c0, 1282);
    checkOutput("start_width_cont", start_cnt, SC);

    runFrame(1, 0, c0);
    checkOutput("start_cycle_gap", start_cyc - c0, 2562);
    checkOutput("start_width_gap", start_cnt, SC);

    runFrame(2, 300, c0);
    applyReset();
    runFrame(2, 0, c0);
    checkOutput("start_width_rand", start_cnt, SC);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
